led_pattern_gen: RTL and testbench

Multi-channel LED pattern generator: the parametrised successor of the single fixed-rate board blinker. It drives NUM_LEDS outputs, each independently configurable at runtime as off, solid on, continuous blink, or a counted burst of blinks. A cfg valid/ready port writes one channel per accepted beat. The block contains its own reset synchroniser and tick prescaler, and sits directly at the top level next to the board LED pins.

---
 rtl/led_pattern_gen.sv | 101 ++++++++++
 tb/tb_led_pattern_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: per-channel LED driver (off / on / blink / counted burst) with
// its own reset synchroniser and tick prescaler.
module led_pattern_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NUM_LEDS = 4,
  parameter int PERIOD_W = 12,
  parameter bit LED_ACTIVE_LOW = 1'b0,
  localparam int CH_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst_n_async,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_on_time,
  input  logic [7:0]          cfg_count,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] busy
);
  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(TICK_DIV);
  typedef enum logic [1:0] {OFF = 2'd0, ON = 2'd1, BLINK = 2'd2, BURST = 2'd3} mode_e;
  logic [1:0] sync_q;
  logic rst_n;
  logic [DIV_W-1:0] div_q, div_d;
  logic tick, accept;
  mode_e mode_n;
  logic [PERIOD_W-1:0] per_n;
  always_ff @(posedge clk or negedge rst_n_async)
    if (!rst_n_async) sync_q <= '0;
    else sync_q <= {sync_q[0], 1'b1};
  assign rst_n = sync_q[1];
  assign cfg_ready = rst_n;
  assign accept = cfg_valid && cfg_ready;
  assign tick = div_q == DIV_W'(TICK_DIV - 1);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_q <= '0;
    else div_q <= div_d;
  // An empty burst is indistinguishable from OFF, so store it that way.
  assign mode_n = (cfg_mode == BURST && cfg_count == 8'd0) ? OFF : mode_e'(cfg_mode);
  assign per_n = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
  for (genvar c = 0; c < NUM_LEDS; c++) begin : g_ch
    mode_e mode_q, mode_d;
    logic [PERIOD_W-1:0] per_q, per_d, on_q, on_d, ph_q, ph_d;
    logic [7:0] cnt_q, cnt_d;
    logic led_q, led_d, busy_q, busy_d;
    logic wr, run, wrap;
    assign wr = accept && cfg_ch == CH_W'(c);
    assign run = mode_q == BLINK || mode_q == BURST;
    assign wrap = ph_q == per_q - PERIOD_W'(1);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        mode_q <= OFF;
        per_q <= PERIOD_W'(1);
        on_q <= '0;
        ph_q <= '0;
        cnt_q <= '0;
        led_q <= LED_ACTIVE_LOW;
        busy_q <= 1'b0;
      end else begin
        mode_q <= mode_d;
        per_q <= per_d;
        on_q <= on_d;
        ph_q <= ph_d;
        cnt_q <= cnt_d;
        led_q <= led_d ^ LED_ACTIVE_LOW;
        busy_q <= busy_d;
      end
    // A config beat overrides a coincident tick for its own channel.
    always_comb begin
      mode_d = mode_q;
      per_d = per_q;
      on_d = on_q;
      ph_d = ph_q;
      cnt_d = cnt_q;
      if (wr) begin
        mode_d = mode_n;
        per_d = per_n;
        on_d = cfg_on_time;
        ph_d = '0;
        cnt_d = cfg_count;
      end else if (tick && run) begin
        ph_d = wrap ? '0 : ph_q + PERIOD_W'(1);
        if (wrap && mode_q == BURST) begin
          cnt_d = cnt_q - 8'd1;
          mode_d = (cnt_q == 8'd1) ? OFF : BURST;
        end
      end
    end
    always_comb begin
      led_d = mode_q == ON || (run && ph_q < on_q);
      busy_d = run;
    end
    assign led[c] = led_q;
    assign busy[c] = busy_q;
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed checks of led_pattern_gen (main, active-low and 5-LED instances).
module tb_led_pattern_gen;
  logic clk = 1'b0;
  logic rst_n_async = 1'b0;
  logic cfg_valid = 1'b0;
  logic valid5 = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [2:0] ch5 = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_period = '0;
  logic [3:0] cfg_on_time = '0;
  logic [7:0] cfg_count = '0;
  logic rdy, rdy_al, rdy5;
  logic [3:0] led, busy, led_al, busy_al;
  logic [4:0] led5, busy5;
  int n_assert = 0;
  int n_fail = 0;
  int rel = 0;

  always #5 clk = ~clk;
  // Edges seen since rst_n_async was released.
  always @(posedge clk) rel <= rst_n_async ? rel + 1 : 0;

  led_pattern_gen #(.CLK_FREQ_HZ(100), .TICK_HZ(10), .NUM_LEDS(4), .PERIOD_W(4), .LED_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n_async(rst_n_async), .cfg_valid(cfg_valid), .cfg_ready(rdy), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_on_time(cfg_on_time), .cfg_count(cfg_count),
    .led(led), .busy(busy));
  led_pattern_gen #(.CLK_FREQ_HZ(100), .TICK_HZ(10), .NUM_LEDS(4), .PERIOD_W(4), .LED_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n_async(rst_n_async), .cfg_valid(cfg_valid), .cfg_ready(rdy_al), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_on_time(cfg_on_time), .cfg_count(cfg_count),
    .led(led_al), .busy(busy_al));
  led_pattern_gen #(.CLK_FREQ_HZ(100), .TICK_HZ(10), .NUM_LEDS(5), .PERIOD_W(4), .LED_ACTIVE_LOW(1'b0)) dut5 (
    .clk(clk), .rst_n_async(rst_n_async), .cfg_valid(valid5), .cfg_ready(rdy5), .cfg_ch(ch5),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_on_time(cfg_on_time), .cfg_count(cfg_count),
    .led(led5), .busy(busy5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] m, input logic [3:0] p, input logic [3:0] t, input logic [7:0] n);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_mode = m; cfg_period = p; cfg_on_time = t; cfg_count = n;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic cfg5(input logic [2:0] ch, input logic [1:0] m, input logic [3:0] p, input logic [3:0] t);
    valid5 = 1'b1; ch5 = ch; cfg_mode = m; cfg_period = p; cfg_on_time = t; cfg_count = 8'd1;
    @(negedge clk);
    valid5 = 1'b0;
  endtask

  // Leaves the bench at the negedge of a cycle in which the prescaler tick is high.
  task automatic to_tick();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(rel >= 11 && rel % 10 == 1) && k < 40);
    chk("tick sync", k < 40, 1'b1);
  endtask

  task automatic steady(input string tag, input int n, input logic [3:0] el, input logic [3:0] eb);
    logic [3:0] nl;
    nl = ~el;
    repeat (n) begin
      @(negedge clk);
      chk({tag, " led"}, led, el);
      chk({tag, " busy"}, busy, eb);
      chk({tag, " led_al"}, led_al, nl);
    end
  endtask

  // Sample i is taken after edge E+i, E being the tick-aligned config edge; b = 0 means endless blink.
  task automatic pat(input string tag, input int ch, input int p, input int t, input int b,
                     input int i0, input int n, input logic [3:0] ol, input logic [3:0] ob);
    for (int i = i0 + 1; i <= i0 + n; i++) begin
      int j;
      logic act;
      logic [3:0] el, eb, nl;
      @(negedge clk);
      j = (i - 1) / 10;
      act = (b == 0) || (j < b * p);
      el = ol;
      eb = ob;
      el[ch] = act && ((j % p) < t);
      eb[ch] = act;
      nl = ~el;
      chk({tag, " led"}, led, el);
      chk({tag, " busy"}, busy, eb);
      chk({tag, " led_al"}, led_al, nl);
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n_async = 1'b1;
    @(negedge clk);
    chk("ready edge1", rdy, 1'b0);
    @(negedge clk);
    chk("ready edge2", rdy, 1'b1);
    chk("ready5 edge2", rdy5, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset led", led, 4'h0);
    chk("reset busy", busy, 4'h0);
    chk("reset ready", rdy, 1'b0);
    chk("reset led_al", led_al, 4'hf);
    release_rst();
    steady("idle", 3, 4'h0, 4'h0);
    cfg(2'd0, 2'd1, 4'd1, 4'd0, 8'd0);
    chk("on latency", led, 4'h0);
    @(negedge clk);
    chk("on lit", led, 4'h1);
    chk("on busy", busy, 4'h0);
    cfg5(3'd0, 2'd1, 4'd1, 4'd0);
    @(negedge clk);
    chk("ch5 base led", led5, 5'h01);
    cfg5(3'd5, 2'd1, 4'd1, 4'd0);
    @(negedge clk);
    chk("oob5 led", led5, 5'h01);
    cfg5(3'd7, 2'd2, 4'd2, 4'd1);
    @(negedge clk);
    chk("oob7 led", led5, 5'h01);
    chk("oob7 busy", busy5, 5'h00);
    to_tick(); cfg(2'd1, 2'd2, 4'd4, 4'd1, 8'd0);
    pat("blink t1", 1, 4, 1, 0, 0, 60, 4'h1, 4'h0);
    to_tick(); cfg(2'd1, 2'd2, 4'd4, 4'd0, 8'd0);
    pat("blink t0", 1, 4, 0, 0, 0, 20, 4'h1, 4'h0);
    to_tick(); cfg(2'd1, 2'd2, 4'd4, 4'd5, 8'd0);
    pat("blink t5", 1, 4, 5, 0, 0, 20, 4'h1, 4'h0);
    to_tick(); cfg(2'd1, 2'd2, 4'd0, 4'd1, 8'd0);
    pat("blink p0", 1, 1, 1, 0, 0, 20, 4'h1, 4'h0);
    cfg(2'd1, 2'd0, 4'd1, 4'd0, 8'd0);
    to_tick(); cfg(2'd2, 2'd3, 4'd2, 4'd1, 8'd3);
    pat("burst3", 2, 2, 1, 3, 0, 80, 4'h1, 4'h0);
    cfg(2'd2, 2'd2, 4'd2, 4'd1, 8'd0);
    @(negedge clk);
    chk("pre-zero busy", busy, 4'h4);
    cfg(2'd2, 2'd3, 4'd2, 4'd1, 8'd0);
    steady("burst0", 20, 4'h1, 4'h0);
    to_tick(); cfg(2'd3, 2'd2, 4'd4, 4'd1, 8'd0);
    pat("ch3 run", 3, 4, 1, 0, 0, 25, 4'h1, 4'h0);
    cfg(2'd1, 2'd0, 4'd1, 4'd0, 8'd0);
    pat("ch3 other", 3, 4, 1, 0, 26, 2, 4'h1, 4'h0);
    to_tick(); cfg(2'd3, 2'd2, 4'd4, 4'd1, 8'd0);
    pat("ch3 restart", 3, 4, 1, 0, 0, 45, 4'h1, 4'h0);
    cfg(2'd3, 2'd0, 4'd1, 4'd0, 8'd0);
    to_tick(); cfg(2'd2, 2'd3, 4'd2, 4'd1, 8'd3);
    pat("burst pre-rst", 2, 2, 1, 3, 0, 15, 4'h1, 4'h0);
    @(posedge clk);
    #2 rst_n_async = 1'b0;
    #1;
    chk("async led", led, 4'h0);
    chk("async busy", busy, 4'h0);
    chk("async ready", rdy, 1'b0);
    chk("async led_al", led_al, 4'hf);
    steady("in reset", 3, 4'h0, 4'h0);
    release_rst();
    steady("post reset", 40, 4'h0, 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
